huc_mmu: RTL

- Address-translation and bus-timing stage directly downstream of cpu_65c02.
- Maps the CPU's 16-bit logical bus AB onto the 21-bit HuC6280 physical bus through eight 8-bit mapping registers (MPR0–MPR7), selected by AB[15:13].
- Serves the TAM/TMA register-access path.
- Decodes the I/O page and stretches VDC accesses with wait states by pulling RDY low while the CPU runs in high-speed mode.

---
 rtl/huc_mmu_if.sv | 27 ++
 rtl/huc_mmu.sv | 124 ++++++++++++
 2 files changed

// File: rtl/huc_mmu_if.sv
// huc_mmu_if: CPU-side bus between cpu_65c02 and the huc_mmu address stage.
//   master modport: CPU side. It drives the logical address, the strobes and the
//                   TAM data, and it receives PA, the decodes, the TMA data and RDY.
//   slave  modport: huc_mmu side.
interface huc_mmu_if;
    logic [15:0] AB;
    logic        WE;
    logic        speed_hi;
    logic        mpr_we;
    logic [7:0]  mpr_sel;
    logic [7:0]  mpr_wdata;
    logic [7:0]  mpr_rdata;
    logic [20:0] PA;
    logic        io_sel;
    logic        vdc_sel;
    logic        RDY;

    modport master (
        output AB, WE, speed_hi, mpr_we, mpr_sel, mpr_wdata,
        input  mpr_rdata, PA, io_sel, vdc_sel, RDY
    );

    modport slave (
        input  AB, WE, speed_hi, mpr_we, mpr_sel, mpr_wdata,
        output mpr_rdata, PA, io_sel, vdc_sel, RDY
    );
endinterface

// File: rtl/huc_mmu.sv
// huc_mmu: HuC6280 MMU and bus-timing stage.
//   The stage maps the 16-bit logical address onto the 21-bit physical address through
//   MPR0..MPR7, which are selected by AB[15:13]. It serves the TAM/TMA path and decodes
//   the I/O page and the VDC window. VDC accesses made in high-speed mode are stretched
//   by holding RDY low.
// Ports:
//   clk   - system clock. All state changes on the rising edge.
//   reset - asynchronous, active-high reset.
//   bus   - huc_mmu_if.slave: AB, WE, speed_hi, mpr_we/sel/wdata in;
//           mpr_rdata, PA, io_sel, vdc_sel, RDY out.
// Build option:
//   MMU_IO_WAIT_EN - when defined, the wait FSM and its counter are built.
//                    When undefined, RDY is tied high and speed_hi is ignored.
// States (MMU_IO_WAIT_EN):
//   state  | meaning
//   S_IDLE | no stall pending. RDY = !hit, and a hit starts a stretch.
//   S_WAIT | stall cycles. RDY = 0, and the counter runs down.
//   S_DONE | held access completes. RDY = 1, and hit is ignored.
module huc_mmu #(
    parameter int         VDC_WAIT  = 1,
    parameter logic [7:0] IO_BANK   = 8'hFF,
    parameter logic [7:0] MPR_RESET = 8'h00
) (
    input logic         clk,
    input logic         reset,
    huc_mmu_if.slave    bus
);

    logic [7:0] mpr_q [8];
    logic [7:0] mpr_d [8];
    logic [7:0] bank;
    logic       io_sel_w;
    logic       vdc_sel_w;
    logic [7:0] rdata_w;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            mpr_d[i] = (bus.mpr_we && bus.mpr_sel[i]) ? bus.mpr_wdata : mpr_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mpr_q[i] <= MPR_RESET;
        end else begin
            for (int i = 0; i < 8; i++) mpr_q[i] <= mpr_d[i];
        end
    end

    // The mapping reads the registered MPRs, so an access in the TAM cycle itself
    // still sees the old bank.
    assign bank      = mpr_q[bus.AB[15:13]];
    assign io_sel_w  = (bank == IO_BANK);
    assign vdc_sel_w = io_sel_w && (bus.AB[12:10] == 3'b000);

    always_comb begin
        rdata_w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bus.mpr_sel[i]) rdata_w = rdata_w | mpr_q[i];
        end
    end

    assign bus.PA        = {bank, bus.AB[12:0]};
    assign bus.io_sel    = io_sel_w;
    assign bus.vdc_sel   = vdc_sel_w;
    assign bus.mpr_rdata = rdata_w;

`ifdef MMU_IO_WAIT_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] WAIT_LOAD = 8'((VDC_WAIT > 0) ? (VDC_WAIT - 1) : 0);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hit;
    logic       rdy_w;

    assign hit = vdc_sel_w && bus.speed_hi && (VDC_WAIT != 0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_w   = 1'b1;
        case (state_q)
            S_IDLE: begin
                rdy_w = !hit;
                if (hit) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = (VDC_WAIT > 1) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                rdy_w = 1'b0;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = S_DONE;
            end
            S_DONE: begin
                // The CPU still holds the VDC address here. Returning to IDLE without
                // looking at hit keeps that held address from starting a second stretch.
                rdy_w   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A stall must never be seen while reset is held, even if the address decodes
    // as a VDC hit.
    assign bus.RDY = reset | rdy_w;
`else
    assign bus.RDY = 1'b1;
`endif

endmodule
